// File: rtl/serial_pack_pkg.sv
// Shared definitions for the serial word packer: counter sizing and bit order.
package serial_pack_pkg;

  // First-received bit lands in the word MSB.
  localparam bit MSB_FIRST = 1'b1;

  function automatic int unsigned cnt_w(input int unsigned width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/serial_word_packer_if.sv
// Serial-in / word-out handshake bundle of the packer.
interface serial_word_packer_if
  import serial_pack_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) ();

  localparam int unsigned CNT_W = cnt_w(DATA_WIDTH);

  logic                  din;
  logic                  din_valid;
  logic                  din_ready;
  logic                  flush;
  logic [DATA_WIDTH-1:0] dout;
  logic                  dout_valid;
  logic                  dout_ready;
  logic [CNT_W-1:0]      bit_cnt;

  modport master (
    output din, din_valid, flush, dout_ready,
    input  din_ready, dout, dout_valid, bit_cnt
  );

  modport slave (
    input  din, din_valid, flush, dout_ready,
    output din_ready, dout, dout_valid, bit_cnt
  );

endinterface

// File: rtl/serial_word_out_reg.sv
// One-entry valid/ready holding register; contents stay stable until drained.
module serial_word_out_reg #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o
);

  logic [WIDTH-1:0] data_q;
  logic             valid_q;

  // A load wins over a drain so back-to-back words leave no bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (load_i) begin
      data_q  <= data_i;
      valid_q <= 1'b1;
    end else if (valid_q && ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/serial_word_packer.sv
// Packs a 1-bit serial stream into DATA_WIDTH-bit words behind a one-entry output register.
module serial_word_packer
  import serial_pack_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 resetn,
  serial_word_packer_if.slave  bus
);

  localparam int unsigned CNT_W = cnt_w(DATA_WIDTH);
  // The final bit goes straight into the output word, so W-1 bits of storage suffice.
  localparam int unsigned SR_W  = DATA_WIDTH - 1;

  logic [SR_W-1:0]       sr_q, sr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] word_c;
  logic                  last_c;
  logic                  din_ready_c;
  logic                  accept_c;
  logic                  load_c;

  assign last_c      = (cnt_q == CNT_W'(DATA_WIDTH - 1));
  assign din_ready_c = !bus.flush && !(last_c && bus.dout_valid && !bus.dout_ready);
  assign accept_c    = bus.din_valid && din_ready_c;
  assign load_c      = accept_c && last_c;

  always_comb begin
    if (MSB_FIRST) word_c = {sr_q, bus.din};
    else           word_c = {bus.din, sr_q};
  end

  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (bus.flush) begin
      sr_d  = '0;
      cnt_d = '0;
    end else if (accept_c) begin
      sr_d  = MSB_FIRST ? word_c[SR_W-1:0] : word_c[DATA_WIDTH-1:1];
      cnt_d = last_c ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

  serial_word_out_reg #(
    .WIDTH (DATA_WIDTH)
  ) u_out_reg (
    .clk     (clk),
    .rst_n   (resetn),
    .load_i  (load_c),
    .data_i  (word_c),
    .ready_i (bus.dout_ready),
    .data_o  (bus.dout),
    .valid_o (bus.dout_valid)
  );

  assign bus.din_ready = din_ready_c;
  assign bus.bit_cnt   = cnt_q;

endmodule

// File: tb/tb_serial_word_packer.sv
// Scoreboard bench for serial_word_packer: directed vectors plus a long randomised-handshake run.
module tb_serial_word_packer;
  import serial_pack_pkg::*;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  serial_word_packer_if #(.DATA_WIDTH(8)) if8 ();
  serial_word_packer_if #(.DATA_WIDTH(5)) if5 ();

  serial_word_packer #(.DATA_WIDTH(8)) dut8 (.clk(clk), .resetn(resetn), .bus(if8));
  serial_word_packer #(.DATA_WIDTH(5)) dut5 (.clk(clk), .resetn(resetn), .bus(if5));

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  logic [7:0]  exp_q[$];
  bit          rand_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_pal5(input logic [4:0] w);
    is_pal5 = 1'b1;
    for (int i = 0; i < 2; i++) if (w[i] != w[4-i]) is_pal5 = 1'b0;
  endfunction

  // Monitor: every drain seen before a rising edge is checked against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (resetn && if8.dout_valid && if8.dout_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_word: got %h with empty scoreboard at %0t", if8.dout, $time);
        end else begin
          check("word", 32'(if8.dout), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_en) if8.dout_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic send_bit(input logic b, input int exp_cnt);
    int budget;
    budget = 0;
    if8.din       = b;
    if8.din_valid = 1'b1;
    @(negedge clk);
    if (exp_cnt >= 0) check("bit_cnt", 32'(if8.bit_cnt), 32'(exp_cnt));
    while (!if8.din_ready && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    if (!if8.din_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL din_ready_timeout: got 0 expected 1 at %0t", $time);
    end
    @(posedge clk);
    #1;
    if8.din_valid = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w, input bit chk_cnt);
    for (int i = 0; i < 8; i++)
      send_bit(MSB_FIRST ? w[7-i] : w[i], chk_cnt ? i : -1);
  endtask

  initial begin
    logic [7:0] w;
    logic [7:0] m;
    logic       b;
    logic [4:0] v5;
    int         budget;

    if8.din = 1'b0; if8.din_valid = 1'b0; if8.flush = 1'b0; if8.dout_ready = 1'b0;
    if5.din = 1'b0; if5.din_valid = 1'b0; if5.flush = 1'b0; if5.dout_ready = 1'b0;

    #1;
    check("rst_dout", 32'(if8.dout), 32'h0);
    check("rst_dout_valid", 32'(if8.dout_valid), 32'h0);
    check("rst_bit_cnt", 32'(if8.bit_cnt), 32'h0);
    check("rst_din_ready", 32'(if8.din_ready), 32'h1);
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;

    // Single word with the consumer always ready.
    if8.dout_ready = 1'b1;
    exp_q.push_back(8'hB2);
    send_word(8'hB2, 1'b1);
    @(negedge clk);
    check("t1_valid_after_last", 32'(if8.dout_valid), 32'h1);
    check("t1_cnt_wrap", 32'(if8.bit_cnt), 32'h0);
    @(negedge clk);
    check("t1_valid_one_cycle", 32'(if8.dout_valid), 32'h0);

    // Back-to-back words with the consumer stalled until the second word completes.
    @(posedge clk); #1;
    if8.dout_ready = 1'b0;
    exp_q.push_back(8'hB2);
    exp_q.push_back(8'h4D);
    send_word(8'hB2, 1'b0);
    w = 8'h4D;
    for (int i = 0; i < 7; i++) send_bit(w[7-i], -1);
    if8.din = w[0];
    if8.din_valid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("t2_stall_ready", 32'(if8.din_ready), 32'h0);
      check("t2_stall_cnt", 32'(if8.bit_cnt), 32'h7);
      check("t2_hold_dout", 32'(if8.dout), 32'hB2);
      check("t2_hold_valid", 32'(if8.dout_valid), 32'h1);
      @(posedge clk); #1;
    end
    if8.dout_ready = 1'b1;
    @(negedge clk);
    check("t2_unstall_ready", 32'(if8.din_ready), 32'h1);
    @(posedge clk); #1;
    if8.din_valid = 1'b0;
    @(negedge clk);
    check("t2_second_dout", 32'(if8.dout), 32'h4D);
    check("t2_second_valid", 32'(if8.dout_valid), 32'h1);

    // Flush of a partial word; the flushed cycle's bit must not be consumed.
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) send_bit(1'b1, i);
    if8.din = 1'b1;
    if8.din_valid = 1'b1;
    if8.flush = 1'b1;
    @(negedge clk);
    check("t3_flush_ready", 32'(if8.din_ready), 32'h0);
    check("t3_pre_flush_cnt", 32'(if8.bit_cnt), 32'h3);
    @(posedge clk); #1;
    if8.flush = 1'b0;
    if8.din_valid = 1'b0;
    @(negedge clk);
    check("t3_post_flush_cnt", 32'(if8.bit_cnt), 32'h0);
    @(posedge clk); #1;
    exp_q.push_back(8'h0F);
    send_word(8'h0F, 1'b1);
    repeat (2) @(negedge clk);

    // Asynchronous reset mid-word with a pending output word.
    @(posedge clk); #1;
    if8.dout_ready = 1'b0;
    send_word(8'h3C, 1'b0);
    send_bit(1'b1, 0); send_bit(1'b0, 1); send_bit(1'b1, 2); send_bit(1'b0, 3); send_bit(1'b1, 4);
    @(negedge clk);
    check("t4_pending_valid", 32'(if8.dout_valid), 32'h1);
    check("t4_partial_cnt", 32'(if8.bit_cnt), 32'h5);
    @(posedge clk); #2;
    resetn = 1'b0;
    #1;
    check("t4_async_dout", 32'(if8.dout), 32'h0);
    check("t4_async_valid", 32'(if8.dout_valid), 32'h0);
    check("t4_async_cnt", 32'(if8.bit_cnt), 32'h0);
    check("t4_async_ready", 32'(if8.din_ready), 32'h1);
    @(posedge clk); #1;
    resetn = 1'b1;
    if8.dout_ready = 1'b1;
    exp_q.push_back(8'hA5);
    send_word(8'hA5, 1'b1);
    repeat (2) @(negedge clk);

    // Odd width feeding a palindrome check.
    @(posedge clk); #1;
    if5.dout_ready = 1'b1;
    v5 = 5'b10001;
    for (int i = 0; i < 5; i++) begin
      if5.din = v5[4-i];
      if5.din_valid = 1'b1;
      @(posedge clk); #1;
    end
    if5.din_valid = 1'b0;
    @(negedge clk);
    check("t5_dout", 32'(if5.dout), 32'h11);
    check("t5_valid", 32'(if5.dout_valid), 32'h1);
    check("t5_palindrome", 32'(is_pal5(if5.dout)), 32'h1);

    // Random valid/ready over many words; the model regroups the sent bits into words.
    @(posedge clk); #1;
    rand_en = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      w = 8'($urandom);
      m = '0;
      for (int i = 0; i < 8; i++) begin
        b = MSB_FIRST ? w[7-i] : w[i];
        if (MSB_FIRST) m = {m[6:0], b};
        else           m[i] = b;
      end
      exp_q.push_back(m);
      for (int i = 0; i < 8; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          if8.din = 1'($urandom);
          if8.din_valid = 1'b0;
          @(posedge clk); #1;
        end
        send_bit(MSB_FIRST ? w[7-i] : w[i], -1);
      end
    end
    rand_en = 1'b0;
    if8.dout_ready = 1'b1;
    budget = 0;
    while (exp_q.size() != 0 && budget < 50) begin
      @(posedge clk);
      budget++;
    end
    @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
